// File: rtl/galaga_pkg.sv
// Shared types and widths for the wave status tracker.
package galaga_pkg;

   typedef enum logic [2:0] {
      WAVE1,
      WAIT_BOSS,
      BOSS,
      CLEARED,
      DEAD
   } wave_state_t;

   localparam int unsigned LIVES_W   = 3;
   localparam int unsigned HP_W      = 8;
   localparam int unsigned MAX_LIVES = 7;

endpackage

// File: rtl/frame_countdown.sv
// Frame-based countdown: loads a value, decrements on frame_tick, busy until it reaches zero.
module frame_countdown #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   input  logic             frame_tick,
   output logic             busy
);

   logic [CNT_W-1:0] count;

   // busy drops on the same tick that takes the count to zero
   always_ff @(posedge Clk) begin
      if (Reset || clear) begin
         count <= '0;
         busy  <= 1'b0;
      end else if (load) begin
         count <= load_value;
         busy  <= (load_value != '0);
      end else if (frame_tick && busy) begin
         count <= count - CNT_W'(1);
         busy  <= (count != CNT_W'(1));
      end
   end

endmodule

// File: rtl/wave_status_tracker.sv
// Tracks formation alive mask, boss HP and player lives; raises died/killed_all flags.
// Optional macro BONUS_LIFE_EN grants one life (saturating) when the formation is cleared.
module wave_status_tracker
   import galaga_pkg::*;
#(
   parameter int unsigned NUM_ENEMIES   = 16,
   parameter int unsigned BOSS_HP       = 8,
   parameter int unsigned START_LIVES   = 3,
   parameter int unsigned INVULN_FRAMES = 60
) (
   input  logic                           Clk,
   input  logic                           Reset,
   input  logic                           frame_tick,
   input  logic                           play,
   input  logic                           boss_fight,
   input  logic                           enemy_hit,
   input  logic [$clog2(NUM_ENEMIES)-1:0] enemy_hit_idx,
   input  logic                           boss_hit,
   input  logic                           player_hit,
   output logic [NUM_ENEMIES-1:0]         enemy_alive,
   output logic [HP_W-1:0]                boss_hp,
   output logic [LIVES_W-1:0]             lives,
   output logic                           invuln,
   output logic                           died,
   output logic                           killed_all1,
   output logic                           killed_all2
);

`ifdef BONUS_LIFE_EN
   localparam bit BONUS_EN = 1'b1;
`else
   localparam bit BONUS_EN = 1'b0;
`endif

   localparam int unsigned INV_W = 8;

   wave_state_t            state, state_n;
   logic [NUM_ENEMIES-1:0] alive_n;
   logic [HP_W-1:0]        hp_n;
   logic [LIVES_W-1:0]     lives_n;
   logic                   died_n, k1_n, k2_n;
   logic                   cd_load, player_ok, bonus;

   frame_countdown #(.CNT_W(INV_W)) u_invuln (
      .Clk        (Clk),
      .Reset      (Reset),
      .clear      (!play),
      .load       (cd_load),
      .load_value (INV_W'(INVULN_FRAMES)),
      .frame_tick (frame_tick),
      .busy       (invuln)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= WAVE1;
         enemy_alive <= '1;
         boss_hp     <= HP_W'(BOSS_HP);
         lives       <= LIVES_W'(START_LIVES);
         died        <= 1'b0;
         killed_all1 <= 1'b0;
         killed_all2 <= 1'b0;
      end else begin
         state       <= state_n;
         enemy_alive <= alive_n;
         boss_hp     <= hp_n;
         lives       <= lives_n;
         died        <= died_n;
         killed_all1 <= k1_n;
         killed_all2 <= k2_n;
      end
   end

   always_comb begin
      state_n   = state;
      alive_n   = enemy_alive;
      hp_n      = boss_hp;
      lives_n   = lives;
      died_n    = died;
      k1_n      = killed_all1;
      k2_n      = killed_all2;
      cd_load   = 1'b0;
      player_ok = 1'b0;
      bonus     = 1'b0;
      if (!play) begin
         state_n = WAVE1;
         alive_n = '1;
         hp_n    = HP_W'(BOSS_HP);
         lives_n = LIVES_W'(START_LIVES);
         died_n  = 1'b0;
         k1_n    = 1'b0;
         k2_n    = 1'b0;
      end else begin
         player_ok = player_hit && !invuln &&
                     (state == WAVE1 || state == WAIT_BOSS || state == BOSS);
         case (state)
            WAVE1: begin
               if (enemy_hit && (32'(enemy_hit_idx) < NUM_ENEMIES))
                  alive_n[enemy_hit_idx] = 1'b0;
               if (alive_n == '0) begin
                  k1_n    = 1'b1;
                  state_n = WAIT_BOSS;
                  bonus   = 1'b1;
               end
            end
            WAIT_BOSS: begin
               if (boss_fight)
                  state_n = BOSS;
            end
            BOSS: begin
               if (boss_hit && boss_hp != '0) begin
                  hp_n = boss_hp - HP_W'(1);
                  if (boss_hp == HP_W'(1)) begin
                     k2_n    = 1'b1;
                     state_n = CLEARED;
                  end
               end
            end
            default: ;
         endcase
         // a fatal hit overrides any kill flag raised in the same cycle
         if (player_ok) begin
            if (lives <= LIVES_W'(1)) begin
               lives_n = '0;
               died_n  = 1'b1;
               k1_n    = killed_all1;
               k2_n    = killed_all2;
               state_n = DEAD;
            end else begin
               lives_n = lives - LIVES_W'(1);
               cd_load = 1'b1;
            end
         end
         if (BONUS_EN && bonus && state_n != DEAD && lives_n != LIVES_W'(MAX_LIVES))
            lives_n = lives_n + LIVES_W'(1);
      end
   end

endmodule

// File: tb/tb_wave_status_tracker.sv
// Directed self-checking bench for wave_status_tracker.
module tb_wave_status_tracker;

   logic        Clk = 1'b0;
   logic        Reset, frame_tick, play, boss_fight, enemy_hit, boss_hit, player_hit;
   logic [3:0]  enemy_hit_idx;
   logic [15:0] enemy_alive;
   logic [7:0]  boss_hp;
   logic [2:0]  lives;
   logic        invuln, died, killed_all1, killed_all2;

   int checks = 0;
   int errors = 0;

`ifdef BONUS_LIFE_EN
   localparam logic [2:0] LIVES_AFTER_CLEAR = 3'd4;
`else
   localparam logic [2:0] LIVES_AFTER_CLEAR = 3'd3;
`endif

   wave_status_tracker dut (
      .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .play(play),
      .boss_fight(boss_fight), .enemy_hit(enemy_hit), .enemy_hit_idx(enemy_hit_idx),
      .boss_hit(boss_hit), .player_hit(player_hit), .enemy_alive(enemy_alive),
      .boss_hp(boss_hp), .lives(lives), .invuln(invuln), .died(died),
      .killed_all1(killed_all1), .killed_all2(killed_all2)
   );

   always #5 Clk = ~Clk;

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_init();
      Reset = 1'b1; play = 1'b0; frame_tick = 1'b0; boss_fight = 1'b0;
      enemy_hit = 1'b0; enemy_hit_idx = '0; boss_hit = 1'b0; player_hit = 1'b0;
      cyc(); cyc();
      Reset = 1'b0; play = 1'b1;
      cyc();
   endtask

   task automatic kill(input int idx);
      enemy_hit = 1'b1; enemy_hit_idx = 4'(idx);
      cyc();
      enemy_hit = 1'b0;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1; cyc();
         frame_tick = 1'b0; cyc();
      end
   endtask

   task automatic hit_player();
      player_hit = 1'b1; cyc(); player_hit = 1'b0;
   endtask

   task automatic test_reset();
      do_init();
      checks++; if (enemy_alive !== 16'hFFFF) begin errors++; $display("FAIL reset_alive got %h exp ffff", enemy_alive); end
      checks++; if (boss_hp !== 8'd8) begin errors++; $display("FAIL reset_hp got %0d exp 8", boss_hp); end
      checks++; if (lives !== 3'd3) begin errors++; $display("FAIL reset_lives got %0d exp 3", lives); end
      checks++; if ({invuln, died, killed_all1, killed_all2} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags got %b exp 0000", {invuln, died, killed_all1, killed_all2}); end
   endtask

   task automatic test_formation_clear();
      logic [15:0] exp_mask;
      do_init();
      exp_mask = 16'hFFFF;
      for (int i = 0; i < 16; i++) begin
         kill(i);
         exp_mask[i] = 1'b0;
         checks++; if (enemy_alive !== exp_mask) begin errors++; $display("FAIL clear_mask_%0d got %h exp %h", i, enemy_alive, exp_mask); end
         checks++; if (killed_all1 !== (i == 15)) begin errors++; $display("FAIL clear_k1_%0d got %b exp %b", i, killed_all1, i == 15); end
         if (i == 5) begin
            kill(5);
            checks++; if (enemy_alive !== exp_mask) begin errors++; $display("FAIL double_hit got %h exp %h", enemy_alive, exp_mask); end
         end
      end
      checks++; if (lives !== LIVES_AFTER_CLEAR) begin errors++; $display("FAIL clear_lives got %0d exp %0d", lives, LIVES_AFTER_CLEAR); end
   endtask

   task automatic test_boss();
      for (int i = 0; i < 3; i++) begin
         boss_hit = 1'b1; cyc(); boss_hit = 1'b0;
      end
      checks++; if (boss_hp !== 8'd8) begin errors++; $display("FAIL wait_boss_hp got %0d exp 8", boss_hp); end
      boss_fight = 1'b1; cyc();
      for (int i = 1; i <= 9; i++) begin
         boss_hit = 1'b1; cyc(); boss_hit = 1'b0;
         checks++; if (boss_hp !== ((i >= 8) ? 8'd0 : 8'(8 - i))) begin
            errors++; $display("FAIL boss_hp_%0d got %0d exp %0d", i, boss_hp, (i >= 8) ? 0 : 8 - i); end
         checks++; if (killed_all2 !== (i >= 8)) begin errors++; $display("FAIL boss_k2_%0d got %b exp %b", i, killed_all2, i >= 8); end
      end
      checks++; if (killed_all1 !== 1'b1) begin errors++; $display("FAIL boss_k1_hold got %b exp 1", killed_all1); end
   endtask

   task automatic test_lives();
      do_init();
      hit_player();
      checks++; if (lives !== 3'd2 || invuln !== 1'b1) begin errors++; $display("FAIL hit1 got lives=%0d inv=%b exp 2/1", lives, invuln); end
      frames(10);
      hit_player();
      checks++; if (lives !== 3'd2) begin errors++; $display("FAIL hit_invuln got %0d exp 2", lives); end
      frames(49);
      checks++; if (invuln !== 1'b1) begin errors++; $display("FAIL invuln_59 got %b exp 1", invuln); end
      frames(1);
      checks++; if (invuln !== 1'b0) begin errors++; $display("FAIL invuln_60 got %b exp 0", invuln); end
      hit_player();
      checks++; if (lives !== 3'd1 || invuln !== 1'b1) begin errors++; $display("FAIL hit2 got lives=%0d inv=%b exp 1/1", lives, invuln); end
      frames(59);
      // last tick and a hit together: the hit lands while still invulnerable
      frame_tick = 1'b1; player_hit = 1'b1; cyc(); frame_tick = 1'b0; player_hit = 1'b0;
      checks++; if (lives !== 3'd1 || invuln !== 1'b0) begin errors++; $display("FAIL tick_hit got lives=%0d inv=%b exp 1/0", lives, invuln); end
      hit_player();
      checks++; if (lives !== 3'd0 || died !== 1'b1) begin errors++; $display("FAIL fatal got lives=%0d died=%b exp 0/1", lives, died); end
      kill(0);
      checks++; if (enemy_alive !== 16'hFFFF) begin errors++; $display("FAIL dead_ignore got %h exp ffff", enemy_alive); end
   endtask

   task automatic test_tie();
      do_init();
      hit_player(); frames(60);
      hit_player(); frames(60);
      checks++; if (lives !== 3'd1 || invuln !== 1'b0) begin errors++; $display("FAIL tie_setup got lives=%0d inv=%b exp 1/0", lives, invuln); end
      for (int i = 0; i < 15; i++) kill(i);
      enemy_hit = 1'b1; enemy_hit_idx = 4'd15; player_hit = 1'b1;
      cyc();
      enemy_hit = 1'b0; player_hit = 1'b0;
      checks++; if (died !== 1'b1 || killed_all1 !== 1'b0) begin errors++; $display("FAIL tie got died=%b k1=%b exp 1/0", died, killed_all1); end
      checks++; if (lives !== 3'd0) begin errors++; $display("FAIL tie_lives got %0d exp 0", lives); end
   endtask

   task automatic test_abort();
      do_init();
      for (int i = 0; i < 16; i++) kill(i);
      boss_fight = 1'b1; cyc();
      for (int i = 0; i < 5; i++) begin
         boss_hit = 1'b1; cyc(); boss_hit = 1'b0;
      end
      checks++; if (boss_hp !== 8'd3) begin errors++; $display("FAIL abort_setup got %0d exp 3", boss_hp); end
      boss_fight = 1'b0; play = 1'b0; cyc(); play = 1'b1;
      checks++; if (enemy_alive !== 16'hFFFF || boss_hp !== 8'd8 || lives !== 3'd3) begin
         errors++; $display("FAIL abort_vals got %h/%0d/%0d exp ffff/8/3", enemy_alive, boss_hp, lives); end
      checks++; if ({invuln, died, killed_all1, killed_all2} !== 4'b0000) begin
         errors++; $display("FAIL abort_flags got %b exp 0000", {invuln, died, killed_all1, killed_all2}); end
      cyc();
      kill(3);
      checks++; if (enemy_alive !== 16'hFFF7) begin errors++; $display("FAIL abort_wave1 got %h exp fff7", enemy_alive); end
   endtask

   initial begin
      test_reset();
      test_formation_clear();
      test_boss();
      test_lives();
      test_tie();
      test_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
